// File: rtl/dec8_rr_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one 3-to-8 decoded resource.
// Grants are held for at most MAX_HOLD cycles; all outputs are registered.
module dec8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       req,
  output logic             gnt_valid,
  output logic [2:0]       gnt_idx,
  output logic [7:0]       gnt_onehot,
  output logic             gnt_new
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_n;
  logic [2:0]        ptr, ptr_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic              valid_n;
  logic [2:0]        idx_n;
  logic [7:0]        onehot_n;
  logic              new_n;

  logic [3:0]        pick_idle;
  logic [3:0]        pick_rel;
  logic [2:0]        rel_ptr;
  logic              release_now;

  // Returns {found, index} of the first set request searching upward from p.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] cand;
    res = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = p + 3'(i);
      if (!res[3] && r[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] dec2to4(input logic [1:0] s);
    logic [3:0] d;
    d = '0;
    d[s] = 1'b1;
    return d;
  endfunction

  // Same structure as the downstream decoder: idx[2] picks the half, idx[1:0] decodes within it.
  function automatic logic [7:0] dec3to8(input logic [2:0] s);
    logic [3:0] half;
    half = dec2to4(s[1:0]);
    return {half & {4{s[2]}}, half & {4{~s[2]}}};
  endfunction

  assign rel_ptr     = gnt_idx + 3'd1;
  assign pick_idle   = rr_pick(req, ptr);
  assign pick_rel    = rr_pick(req, rel_ptr);
  assign release_now = !req[gnt_idx] || (hold_cnt == HOLD_LAST);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    valid_n = gnt_valid;
    idx_n   = gnt_idx;
    new_n   = 1'b0;

    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (en && pick_idle[3]) begin
          state_n = GRANT;
          valid_n = 1'b1;
          idx_n   = pick_idle[2:0];
          new_n   = 1'b1;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (!en) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end else if (release_now) begin
          // Searching from gnt_idx+1 leaves the released requester last in line.
          ptr_n = rel_ptr;
          if (pick_rel[3]) begin
            idx_n  = pick_rel[2:0];
            new_n  = 1'b1;
            hold_n = '0;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
          end
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase

    onehot_n = valid_n ? dec3to8(idx_n) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      gnt_new    <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      hold_cnt   <= hold_n;
      gnt_valid  <= valid_n;
      gnt_idx    <= idx_n;
      gnt_onehot <= onehot_n;
      gnt_new    <= new_n;
    end
  end

endmodule

// File: tb/tb_dec8_rr_arbiter.sv
// Scoreboard bench for dec8_rr_arbiter: stimulus queues hand-computed expected
// outputs per cycle, a monitor pops and compares on each falling edge.
module tb_dec8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       gnt_new;

  typedef struct {
    logic       valid;
    logic [2:0] idx;
    logic       is_new;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   step_id = 0;

  dec8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .gnt_new    (gnt_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_onehot(input logic v, input logic [2:0] i);
    logic [7:0] one;
    one = 8'h01;
    return v ? (one << i) : 8'h00;
  endfunction

  task automatic check_outs(input string name, input int id, input logic ev,
                            input logic [2:0] ei, input logic enew);
    logic [12:0] act, req_v;
    act   = {gnt_valid, gnt_idx, gnt_onehot, gnt_new};
    req_v = {ev, ei, exp_onehot(ev, ei), enew};
    checks++;
    if (act === req_v) passed++;
    else $display("FAIL %s#%0d: got valid=%0b idx=%0d onehot=%02h new=%0b, expected valid=%0b idx=%0d onehot=%02h new=%0b",
                  name, id, gnt_valid, gnt_idx, gnt_onehot, gnt_new, ev, ei, exp_onehot(ev, ei), enew);
  endtask

  // Monitor: one expected entry per sampled cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_outs("cycle", e.id, e.valid, e.idx, e.is_new);
        checks++;
        if ($countones(gnt_onehot) <= 1) passed++;
        else $display("FAIL onehot_multi#%0d: got onehot=%02h, expected at most one bit", e.id, gnt_onehot);
      end
    end
  end

  // Drive inputs for one cycle and queue the outputs expected after the next rising edge.
  task automatic step(input logic r_n, input logic e, input logic [7:0] r,
                      input logic ev, input logic [2:0] ei, input logic enew);
    exp_t x;
    @(negedge clk);
    #1;
    rst_n = r_n;
    en    = e;
    req   = r;
    x.valid  = ev;
    x.idx    = ei;
    x.is_new = enew;
    x.id     = step_id;
    step_id++;
    sb.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    #3;
    check_outs("reset", 0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Full request set: rotate 0..7 then back to 0, each held 4 cycles.
    for (int k = 0; k < 33; k++)
      step(1, 1, 8'hFF, 1, 3'((k / 4) % 8), (k % 4) == 0);
    step(1, 0, 8'h01, 0, 3'd0, 0);

    // Sole requester 0 is re-granted every 4 cycles.
    step(1, 1, 8'h01, 1, 3'd0, 1);
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 8'h01, 1, 3'd0, 0);
      step(1, 1, 8'h01, 1, 3'd0, 0);
      step(1, 1, 8'h01, 1, 3'd0, 0);
      step(1, 1, 8'h01, 1, 3'd0, 1);
    end

    // en drop clears the grant; ptr (now 1) is kept, so 8'h03 picks requester 1.
    step(1, 0, 8'h01, 0, 3'd0, 0);
    step(1, 1, 8'h03, 1, 3'd1, 1);
    step(1, 1, 8'h03, 1, 3'd1, 0);

    // Requester 2 granted, dropped after 2 more cycles; 3 follows with a fresh hold count.
    step(1, 1, 8'h0C, 1, 3'd2, 1);
    step(1, 1, 8'h0C, 1, 3'd2, 0);
    step(1, 1, 8'h0C, 1, 3'd2, 0);
    step(1, 1, 8'h08, 1, 3'd3, 1);
    step(1, 1, 8'h08, 1, 3'd3, 0);
    step(1, 1, 8'h08, 1, 3'd3, 0);
    step(1, 1, 8'h08, 1, 3'd3, 0);
    step(1, 1, 8'h08, 1, 3'd3, 1);

    // Grant on 7, then expiry wraps ptr to 0 with no idle cycle.
    step(1, 1, 8'h80, 1, 3'd7, 1);
    step(1, 1, 8'h81, 1, 3'd7, 0);
    step(1, 1, 8'h81, 1, 3'd7, 0);
    step(1, 1, 8'h81, 1, 3'd7, 0);
    step(1, 1, 8'h81, 1, 3'd0, 1);
    step(1, 1, 8'h00, 0, 3'd0, 0);
    step(1, 0, 8'hFF, 0, 3'd0, 0);

    // Asynchronous reset mid-grant.
    step(1, 1, 8'h30, 1, 3'd4, 1);
    step(1, 1, 8'h30, 1, 3'd4, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outs("async_reset", 0, 1'b0, 3'd0, 1'b0);
    step(0, 1, 8'h30, 0, 3'd0, 0);
    step(0, 1, 8'h30, 0, 3'd0, 0);
    step(1, 1, 8'h30, 1, 3'd4, 1);
    step(1, 1, 8'h30, 1, 3'd4, 0);

    for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending entries, expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
